// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM state encoding,
// memory-direction constants and address-field width helpers.
package dcache_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] WDONE  = 2'd3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int lines, input int line_words);
        return addr_w - 2 - $clog2(lines) - $clog2(line_words);
    endfunction

    // Selector width that never collapses to zero bits (LINE_WORDS may be 1).
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU data port and memory port of the cache, bundled for connection.
interface dcache_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read of one word plus its line's
// tag and valid; synchronous word, tag and valid writes; bulk valid clear.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    localparam int IDX_W     = index_bits(LINES),
    localparam int WSEL_W    = sel_bits(LINE_WORDS)
) (
    input  logic              clock,
    input  logic              clear_all_i,
    input  logic [IDX_W-1:0]  rd_index_i,
    input  logic [WSEL_W-1:0] rd_word_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_valid_o,
    output logic [31:0]       rd_data_o,
    input  logic [IDX_W-1:0]  wr_index_i,
    input  logic [WSEL_W-1:0] wr_word_i,
    input  logic [31:0]       wr_data_i,
    input  logic              data_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              tag_we_i,
    input  logic              inv_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];

    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

    always_ff @(posedge clock) begin
        if (clear_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end else if (inv_i) begin
            valid_q[wr_index_i] <= 1'b0;
        end
    end

    // NOTE: tag and data storage is never reset; a clear valid bit is what keeps stale contents unused.
    always_ff @(posedge clock) begin
        if (tag_we_i) tag_q[wr_index_i] <= wr_tag_i;
        if (data_we_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, blocking, write-through / no-write-allocate data cache.
// Define DCACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic        clock,
    input  logic        reset,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WORD_W = word_bits(LINE_WORDS);
    localparam int IDX_W  = index_bits(LINES);
    localparam int TAG_W  = tag_bits(ADDR_W, LINES, LINE_WORDS);
    localparam int WSEL_W = sel_bits(LINE_WORDS);

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> (2 + WORD_W)) & ADDR_W'(LINES - 1));
    endfunction

    function automatic logic [WSEL_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return WSEL_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (2 + WORD_W + IDX_W));
    endfunction

    logic [1:0]        state_q, state_d;
    logic [WSEL_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              hit;
    logic              data_we, tag_we, inv;

    // The WRITE state probes the array with its latched address to decide whether to update.
    assign sel_addr = (state_q == WRITE) ? addr_q : bus.cpu_addr;
    assign hit      = rd_valid && (rd_tag == tag_of(sel_addr));

    dcache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clock       (clock),
        .clear_all_i (!reset),
        .rd_index_i  (idx_of(sel_addr)),
        .rd_word_i   (word_of(sel_addr)),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .wr_index_i  ((state_q == IDLE) ? idx_of(bus.cpu_addr) : idx_of(addr_q)),
        .wr_word_i   ((state_q == REFILL) ? cnt_q : word_of(addr_q)),
        .wr_data_i   ((state_q == REFILL) ? bus.mem_rdata : wdata_q),
        .data_we_i   (data_we),
        .wr_tag_i    (tag_of(addr_q)),
        .tag_we_i    (tag_we),
        .inv_i       (inv)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        inv           = 1'b0;
        bus.stall     = 1'b0;
        bus.cpu_rdata = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_write) begin
                    bus.stall = 1'b1;
                    addr_d    = bus.cpu_addr & ~ADDR_W'(3);
                    wdata_d   = bus.cpu_wdata;
                    state_d   = WRITE;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        bus.cpu_rdata = rd_data;
                    end else begin
                        bus.stall = 1'b1;
                        inv       = 1'b1;
                        addr_d    = bus.cpu_addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
                        cnt_d     = '0;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.stall = 1'b1;
                if (bus.mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                bus.stall = 1'b1;
                if (bus.mem_ack) begin
                    data_we = hit;
                    state_d = WDONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mem_req   = (state_q == REFILL) || (state_q == WRITE);
    assign bus.mem_we    = (state_q == WRITE) ? MEM_WRITE : MEM_READ;
    assign bus.mem_addr  = addr_q | (ADDR_W'(cnt_q) << 2);
    assign bus.mem_wdata = wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    logic        rd_idle;

    assign rd_idle = (state_q == IDLE) && bus.cpu_read && !bus.cpu_write;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (rd_idle && hit)  hit_q  <= hit_q + 32'd1;
            if (rd_idle && !hit) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed CPU accesses against a memory model
// with programmable word latency; stats are checked when DCACHE_STATS_EN is defined.
module tb_dcache_dm;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_if #(.ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_dm #(.LINES(16), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    item_t cpu_q[$];
    item_t mem_q[$];
    logic [31:0] mem_wr [logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 2;
    int wait_n   = 0;
    bit stray    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return 32'hA000_0000 ^ a;
    endfunction

    task automatic exp_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
    endtask

    // Memory model: acks after `lat` cycles of a held request, checks each transfer.
    initial begin
        item_t e;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_n      = 0;
            end
            if (stray) begin
                bus.mem_ack = 1'b1;
                stray       = 1'b0;
            end else if (bus.mem_req) begin
                wait_n++;
                if (wait_n >= lat) begin
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_mem_req: addr 0x%08h we %0d", bus.mem_addr, bus.mem_we);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_addr", bus.mem_addr, e.addr);
                        check("mem_we", 32'(bus.mem_we), 32'(e.we));
                        if (e.we) check("mem_wdata", bus.mem_wdata, e.data);
                    end
                    if (bus.mem_we) mem_wr[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_val(bus.mem_addr);
                    bus.mem_ack = 1'b1;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // Monitor: every access retired by the CPU (request && !stall) is popped and compared.
    initial begin
        item_t e;
        forever begin
            @(negedge clock);
            if (reset && (bus.cpu_read || bus.cpu_write) && !bus.stall) begin
                if (cpu_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_retire: addr 0x%08h", bus.cpu_addr);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.we) check("store_in_memory", mem_val(e.addr), e.data);
                    else      check("load_data", bus.cpu_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Issue one access at #1 after a posedge; returns #1 after the retiring posedge.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_stall, input string name);
        int n;
        cpu_q.push_back('{we, addr, data});
        bus.cpu_read  = !we;
        bus.cpu_write = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = we ? data : 32'h0;
        n = 0;
        forever begin
            @(negedge clock);
            if (!bus.stall || n > 100) break;
            n++;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        @(posedge clock);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic check_stats(input logic [31:0] hits, input logic [31:0] misses);
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, hits);
        check("miss_count", miss_count, misses);
`else
        if (hits == misses + 32'hFFFF_FFFF) $display("stats not built");
`endif
    endtask

    initial begin
        int acks;
        int guard;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check_stats(0, 0);
        @(posedge clock);
        #1;

        // 1: cold miss, latency 2 -> 1 + 4*2 stalled cycles
        lat = 2;
        exp_line(32'h40);
        access(1'b0, 32'h40, 32'hA000_0040, 9, "t1_cold_read");
        // 2: same-line hit
        access(1'b0, 32'h48, 32'hA000_0048, 0, "t2_hit");
        check("t2_no_mem", 32'(mem_q.size()), 32'h0);
        check_stats(2, 1);
        // 3: write hit updates memory and line
        mem_q.push_back('{1'b1, 32'h44, 32'hDEAD_BEEF});
        access(1'b1, 32'h44, 32'hDEAD_BEEF, 3, "t3_write_hit");
        access(1'b0, 32'h44, 32'hDEAD_BEEF, 0, "t3_read_back");
        // 4: write miss, latency 3, no allocate
        lat = 3;
        mem_q.push_back('{1'b1, 32'h400, 32'h1234_5678});
        access(1'b1, 32'h400, 32'h1234_5678, 4, "t4_write_miss");
        access(1'b0, 32'h40, 32'hA000_0040, 0, "t4_still_hit");
        // 5: conflicting tag evicts, latency 1
        lat = 1;
        exp_line(32'h440);
        access(1'b0, 32'h440, 32'hA000_0440, 5, "t5_evict");
        exp_line(32'h40);
        access(1'b0, 32'h40, 32'hA000_0040, 5, "t5_refetch");
        access(1'b0, 32'h44, 32'hDEAD_BEEF, 0, "t5_hit_written");
        check_stats(7, 3);

        // 6: reset after the second word ack of a refill
        lat = 2;
        mem_q.push_back('{1'b0, 32'h80, 32'h0});
        mem_q.push_back('{1'b0, 32'h84, 32'h0});
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h80;
        acks  = 0;
        guard = 0;
        while (acks < 2 && guard < 100) begin
            @(posedge clock);
            if (bus.mem_ack) acks++;
            guard++;
        end
        check("t6_acks_seen", 32'(acks), 32'h2);
        #1;
        reset        = 1'b0;
        bus.cpu_read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("t6_req_dropped", 32'(bus.mem_req), 32'h0);
        check("t6_stall_low", 32'(bus.stall), 32'h0);
        check("t6_mem_addr", bus.mem_addr, 32'h0);
        check("t6_mem_wdata", bus.mem_wdata, 32'h0);
        stray = 1'b1;
        @(negedge clock);
        check("t6_stray_ack_seen", 32'(bus.mem_ack), 32'h1);
        check("t6_stray_no_req", 32'(bus.mem_req), 32'h0);
        @(negedge clock);
        check("t6_after_stray_req", 32'(bus.mem_req), 32'h0);
        check("t6_after_stray_stall", 32'(bus.stall), 32'h0);
        check_stats(0, 0);
        @(posedge clock);
        #1;
        exp_line(32'h40);
        access(1'b0, 32'h40, 32'hA000_0040, 9, "t6_miss_after_reset");
        check_stats(1, 1);

        repeat (3) @(posedge clock);
        check("end_mem_q_empty", 32'(mem_q.size()), 32'h0);
        check("end_cpu_q_empty", 32'(cpu_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
